// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready operation input, a registered
// result output and a registered N,Z,C,V flag register. Data-processing,
// move/offset and address-add operations complete in one cycle. Multiply is
// an iterative shift-add that takes WIDTH cycles and holds the input closed
// while it runs.
//
// Handshake: an operation transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. out_valid
// and ALU_out stay stable until then. A new single-cycle result may replace
// the old one on that same edge.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operation handshake
//   Aport, Bport        operands (WIDTH bits)
//   OP, cmd, set_flags  operation class, operation code, flag update request
//   out_valid/out_ready result handshake
//   ALU_out             registered result
//   flags               registered {N,Z,C,V}
//   busy                high while a multiply iterates
//   dbg_state_o         current FSM state (0 IDLE, 1 MUL)
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Aport,
  input  logic [WIDTH-1:0] Bport,
  input  logic [1:0]       OP,
  input  logic [3:0]       cmd,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             dbg_state_o
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  localparam logic [3:0] CMD_AND = 4'd0;
  localparam logic [3:0] CMD_XOR = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_RSB = 4'd3;
  localparam logic [3:0] CMD_ADD = 4'd4;
  localparam logic [3:0] CMD_ADC = 4'd5;
  localparam logic [3:0] CMD_SBC = 4'd6;
  localparam logic [3:0] CMD_MUL = 4'd9;
  localparam logic [3:0] CMD_CMP = 4'd10;
  localparam logic [3:0] CMD_ORR = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       flags_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             mul_setf_q;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] logic_d;
  logic             is_arith;
  logic             is_logic;
  logic             is_mul;
  logic [WIDTH-1:0] result_d;
  logic             flag_upd;
  logic [3:0]       flags_d;
  logic [WIDTH-1:0] acc_d;
  logic             accept;

  assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign ALU_out     = alu_out_q;
  assign flags       = flags_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

  // Partial-product accumulate for the current multiplier bit.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // One shared adder computes x + y + ci. Subtracts feed the inverted
  // subtrahend, so the carry-out is the no-borrow flag and overflow is the
  // same "equal input signs, different result sign" test as for adds.
  always_comb begin
    add_x    = Aport;
    add_y    = Bport;
    add_ci   = 1'b0;
    logic_d  = '0;
    is_arith = 1'b0;
    is_logic = 1'b0;
    is_mul   = 1'b0;
    if (OP == 2'd0) begin
      case (cmd)
        CMD_AND: begin logic_d = Aport & Bport; is_logic = 1'b1; end
        CMD_XOR: begin logic_d = Aport ^ Bport; is_logic = 1'b1; end
        CMD_ORR: begin logic_d = Aport | Bport; is_logic = 1'b1; end
        CMD_SUB, CMD_CMP: begin
          add_y = ~Bport; add_ci = 1'b1; is_arith = 1'b1;
        end
        CMD_RSB: begin
          add_x = Bport; add_y = ~Aport; add_ci = 1'b1; is_arith = 1'b1;
        end
        CMD_ADD: is_arith = 1'b1;
        CMD_ADC: begin add_ci = flags_q[1]; is_arith = 1'b1; end
        CMD_SBC: begin
          add_y = ~Bport; add_ci = flags_q[1]; is_arith = 1'b1;
        end
        CMD_MUL: is_mul = MUL_EN;
        default: ;
      endcase
    end

    sum_d = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};

    result_d = '0;
    case (OP)
      2'd0: begin
        if (is_arith)      result_d = sum_d[MSB:0];
        else if (is_logic) result_d = logic_d;
      end
      2'd1:    result_d = cmd[3] ? sum_d[MSB:0] : Aport;
      2'd2:    result_d = sum_d[MSB:0];
      default: result_d = '0;
    endcase

    // Undefined commands and non-data-processing classes leave flags alone.
    flag_upd = (OP == 2'd0) && (set_flags || (cmd == CMD_CMP)) &&
               (is_arith || is_logic);
    flags_d = flags_q;
    if (flag_upd) begin
      flags_d[3] = result_d[MSB];
      flags_d[2] = (result_d == '0);
      if (is_arith) begin
        flags_d[1] = sum_d[WIDTH];
        flags_d[0] = (add_x[MSB] == add_y[MSB]) && (sum_d[MSB] != add_x[MSB]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= 4'b0000;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mul_setf_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (is_mul) begin
          state_q    <= MUL;
          busy_q     <= 1'b1;
          cnt_q      <= '0;
          acc_q      <= '0;
          mcand_q    <= Aport;
          mplier_q   <= Bport;
          mul_setf_q <= set_flags;
        end else begin
          alu_out_q   <= result_d;
          out_valid_q <= 1'b1;
          flags_q     <= flags_d;
        end
      end
    end else begin
      // MUL: one multiplier bit per cycle; the last iteration writes the
      // result directly so it appears WIDTH+1 cycles after accept.
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        cnt_q       <= '0;
        alu_out_q   <= acc_d;
        out_valid_q <= 1'b1;
        if (mul_setf_q) begin
          flags_q[3] <= acc_d[MSB];
          flags_q[2] <= (acc_d == '0);
        end
      end else begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expected values.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] Aport = '0;
  logic [W-1:0] Bport = '0;
  logic [1:0]   OP = 2'd0;
  logic [3:0]   cmd = 4'd0;
  logic         set_flags = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ALU_out;
  logic [3:0]   flags;
  logic         busy;
  logic         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Aport      (Aport),
    .Bport      (Bport),
    .OP         (OP),
    .cmd        (cmd),
    .set_flags  (set_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALU_out    (ALU_out),
    .flags      (flags),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present an op at a negedge, confirm in_ready, advance to the next
  // negedge (the op transfers on the edge in between). in_valid stays high so
  // the caller can chain ops back to back.
  task automatic send(input logic [1:0] op, input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sf, input logic [W-1:0] exp_res,
                      input string tag);
    in_valid = 1'b1; OP = op; cmd = c; Aport = a; Bport = b; set_flags = sf;
    exp_q.push_back(exp_res);
    #1;
    check({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
  endtask

  // Drop in_valid with junk on the other inputs; none of it may matter.
  task automatic idle();
    in_valid  = 1'b0;
    OP        = 2'($urandom_range(0, 3));
    cmd       = 4'($urandom_range(0, 15));
    Aport     = $urandom;
    Bport     = $urandom;
    set_flags = 1'($urandom_range(0, 1));
  endtask

  // Scoreboard: compare the pending result against the expected queue.
  task automatic check_out(input string tag, input logic [3:0] exp_flags);
    logic [W-1:0] e;
    check({tag, " out_valid"}, out_valid, 1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed empty expected queue, required an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " ALU_out"}, ALU_out, e);
    end
    check({tag, " flags"}, flags, exp_flags);
  endtask

  // Wait for a multiply result, counting busy and in_ready cycles on the way.
  task automatic wait_mul(output int cyc, output int busy_cyc, output int rdy_cyc);
    cyc = 1; busy_cyc = 0; rdy_cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) busy_cyc++;
      if (in_ready) rdy_cyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, bcyc, rcyc, stray;

    // Reset
    repeat (2) @(negedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst ALU_out", ALU_out, 0);
    check("rst flags", flags, 4'b0000);
    check("rst busy", busy, 0);
    check("rst state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", in_ready, 1);
    @(negedge clk);

    // ADD with carry-out to zero
    send(2'd0, 4'd4, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, "add");
    idle();
    check_out("add", 4'b0110);
    @(negedge clk);
    check("drain out_valid", out_valid, 0);

    // Back-to-back CMP / SBC / ADC / SBC: carry-in comes from the previous op
    send(2'd0, 4'd10, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, "cmp");
    check_out("cmp", 4'b0011);
    send(2'd0, 4'd6, 32'h5, 32'h2, 1'b1, 32'h3, "sbc c1");
    check_out("sbc c1", 4'b0010);
    send(2'd0, 4'd5, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, "adc c1");
    check_out("adc c1", 4'b1001);
    send(2'd0, 4'd6, 32'h5, 32'h2, 1'b1, 32'h2, "sbc c0");
    check_out("sbc c0", 4'b0010);

    // Logic ops (N,Z only), reverse subtract, no-flag sub, undefined cmd
    send(2'd0, 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, "and");
    check_out("and", 4'b1010);
    send(2'd0, 4'd1, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1, 32'h0, "xor");
    check_out("xor", 4'b0110);
    send(2'd0, 4'd12, 32'h12, 32'h21, 1'b0, 32'h33, "orr");
    check_out("orr", 4'b0110);
    send(2'd0, 4'd3, 32'h3, 32'h1, 1'b1, 32'hFFFF_FFFE, "rsb");
    check_out("rsb", 4'b1000);
    send(2'd0, 4'd2, 32'h10, 32'h3, 1'b0, 32'hD, "sub nf");
    check_out("sub nf", 4'b1000);
    send(2'd0, 4'd7, 32'h1, 32'h2, 1'b1, 32'h0, "undef");
    check_out("undef", 4'b1000);

    // Non-data-processing classes never touch flags
    send(2'd1, 4'd8, 32'h10, 32'h20, 1'b1, 32'h30, "op1 add");
    check_out("op1 add", 4'b1000);
    send(2'd1, 4'd0, 32'h10, 32'h20, 1'b1, 32'h10, "op1 mov");
    check_out("op1 mov", 4'b1000);
    send(2'd2, 4'd2, 32'h5, 32'h6, 1'b1, 32'hB, "op2");
    check_out("op2", 4'b1000);
    send(2'd3, 4'd4, 32'h5, 32'h6, 1'b1, 32'h0, "op3");
    check_out("op3", 4'b1000);
    idle();
    @(negedge clk);

    // Backpressure: held result, closed input, replace on release
    out_ready = 1'b0;
    send(2'd0, 4'd4, 32'h1, 32'h2, 1'b0, 32'h3, "bp first");
    check_out("bp first", 4'b1000);
    in_valid = 1'b1; OP = 2'd0; cmd = 4'd4; Aport = 32'h4; Bport = 32'h4; set_flags = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp in_ready", in_ready, 0);
      check("bp hold", ALU_out, 32'h3);
      check("bp valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    exp_q.push_back(32'h8);
    #1;
    check("bp release in_ready", in_ready, 1);
    @(negedge clk);
    idle();
    check_out("bp replace", 4'b1000);
    @(negedge clk);
    check("bp drain", out_valid, 0);

    // Multiply timing and flags (C,V kept from CMP)
    send(2'd0, 4'd10, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, "pre-mul cmp");
    check_out("pre-mul cmp", 4'b0011);
    send(2'd0, 4'd9, 32'h12345, 32'h100, 1'b1, 32'h0123_4500, "mul");
    // Offer an op during the multiply; it must not be taken
    in_valid = 1'b1; OP = 2'd0; cmd = 4'd4; Aport = 32'h1; Bport = 32'h1;
    wait_mul(cyc, bcyc, rcyc);
    idle();
    check("mul latency", cyc, 33);
    check("mul busy cycles", bcyc, 32);
    check("mul in_ready low", rcyc, 0);
    check_out("mul", 4'b0011);
    check("mul busy end", busy, 0);
    @(negedge clk);

    send(2'd0, 4'd9, 32'h8000_0000, 32'h3, 1'b1, 32'h8000_0000, "mul neg");
    idle();
    wait_mul(cyc, bcyc, rcyc);
    check("mul neg latency", cyc, 33);
    check_out("mul neg", 4'b1011);
    @(negedge clk);

    // Reset in the middle of a multiply
    send(2'd0, 4'd9, 32'h3, 32'h5, 1'b1, 32'hF, "mul abort");
    idle();
    repeat (9) @(negedge clk);
    check("abort busy before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort ALU_out", ALU_out, 0);
    check("abort flags", flags, 4'b0000);
    check("abort busy", busy, 0);
    check("abort state", dbg_state, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort in_ready", in_ready, 1);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort no stray result", stray, 0);

    send(2'd0, 4'd4, 32'h2, 32'h3, 1'b1, 32'h5, "post-abort add");
    idle();
    check_out("post-abort add", 4'b0000);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
